// File: rtl/tog_pulse_rx.sv
// rtl/tog_pulse_rx.sv - toggle-to-pulse event receiver with a small pending queue and an ack toggle
//
// Receives events sent as level toggles on tog_in from a remote clock domain.
// The level is synchronised and each detected transition becomes one pending
// event. Up to three events are held. The consumer takes them with an
// evt_valid/evt_ready handshake.
//
// Ports
//   clk        in   single clock; all state updates on posedge
//   reset      in   synchronous, active-high
//   tog_in     in   asynchronous toggle level, one transition per event
//   evt_valid  out  at least one event pending (decoded from pend_cnt)
//   evt_ready  in   consumer takes one event when evt_valid is high
//   ack_tog    out  toggle returned to the sender, flips on each accept
//   pend_cnt   out  pending events, 0..3
//   evt_total  out  accepted-event counter, wraps modulo 2^CNT_W
//   overflow   out  sticky: an event arrived with the queue full and was lost

module tog_pulse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tog_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             ack_tog,
    output logic [1:0]       pend_cnt,
    output logic [CNT_W-1:0] evt_total,
    output logic             overflow
);

    // Priming lasts SYNC_STAGES+1 edges. The counter runs 0..SYNC_STAGES and
    // fits in 3 bits for the legal range of SYNC_STAGES.
    localparam logic [2:0] PRIME_LAST = 3'(SYNC_STAGES);

    typedef enum logic {
        ST_PRIME,
        ST_RUN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [2:0]       prime_cnt;
    logic [2:0]       prime_cnt_nxt;

    logic [SYNC_STAGES-1:0] sync_q;
    logic             sync_out;
    logic             tog_prev;
    logic             primed;
    logic             detect;
    logic             accept;

    logic [1:0]       pend_nxt;
    logic             overflow_nxt;

    // Synchroniser chain: bit 0 samples tog_in. The MSB is the settled level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else if (SYNC_STAGES > 1) begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
        end else begin
            sync_q <= {SYNC_STAGES{tog_in}};
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];

    // tog_prev also follows sync_out during priming. The flops are cleared by
    // reset, so a high tog_in at release ripples through as a 0->1 edge.
    // Masking detect for SYNC_STAGES+1 edges hides that edge. By the end,
    // tog_prev has caught up with the static level.
    always_ff @(posedge clk) begin
        if (reset) begin
            tog_prev <= 1'b0;
        end else begin
            tog_prev <= sync_out;
        end
    end

    // Priming FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_PRIME;
            prime_cnt <= '0;
        end else begin
            state     <= state_nxt;
            prime_cnt <= prime_cnt_nxt;
        end
    end

    // Priming FSM: next state
    always_comb begin
        state_nxt     = state;
        prime_cnt_nxt = prime_cnt;
        case (state)
            ST_PRIME: begin
                if (prime_cnt == PRIME_LAST) begin
                    state_nxt = ST_RUN;
                end else begin
                    prime_cnt_nxt = prime_cnt + 3'd1;
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt     = ST_PRIME;
                prime_cnt_nxt = '0;
            end
        endcase
    end

    assign primed = (state == ST_RUN);
    assign detect = primed & (sync_out ^ tog_prev);

    // evt_valid comes only from the registered count, so evt_ready has no
    // combinational path to it.
    assign evt_valid = (pend_cnt != 2'd0);
    assign accept    = evt_valid & evt_ready;

    // Pending-count update. When the queue is full and an event arrives with
    // no accept, the event is dropped and the drop is recorded.
    always_comb begin
        pend_nxt     = pend_cnt;
        overflow_nxt = overflow;
        if (detect && !accept) begin
            if (pend_cnt == 2'd3) begin
                overflow_nxt = 1'b1;
            end else begin
                pend_nxt = pend_cnt + 2'd1;
            end
        end else if (accept && !detect) begin
            pend_nxt = pend_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_cnt  <= 2'd0;
            overflow  <= 1'b0;
            ack_tog   <= 1'b0;
            evt_total <= '0;
        end else begin
            pend_cnt <= pend_nxt;
            overflow <= overflow_nxt;
            if (accept) begin
                ack_tog   <= ~ack_tog;
                evt_total <= evt_total + 1'b1;
            end
        end
    end

endmodule
